adc_acq_ctrl: RTL and testbench

Acquisition controller that sits around the SPI ADC reader. It issues periodic `start_conversion` pulses to the reader and waits for each `data_ready` pulse, with a timeout. It accumulates 2^LOG2_AVG accepted samples and delivers their truncated mean on `avg_data`/`avg_valid` to the downstream processing logic.

---
 rtl/adc_acq_pkg.sv | 23 ++
 rtl/acq_downcounter.sv | 28 ++
 rtl/adc_acq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_adc_acq_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// Shared types and sizing helpers for the ADC acquisition controller.
package adc_acq_pkg;

  localparam int unsigned ADC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DATA = 2'd2,
    WAIT_TICK = 2'd3
  } acq_state_t;

  // Accumulator width: one sample plus headroom for 2^log2_avg samples.
  function automatic int unsigned acc_width(input int unsigned log2_avg);
    return ADC_WIDTH + log2_avg;
  endfunction

  // Bits needed to hold values 0..max_count-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/acq_downcounter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module acq_downcounter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/adc_acq_ctrl.sv
// Periodic ADC acquisition: issues start pulses, waits for samples with a
// timeout and delivers the truncated mean of 2^LOG2_AVG accepted samples.
// Optional hysteretic threshold alarm is built when ADC_ALARM_EN is defined.
module adc_acq_ctrl
  import adc_acq_pkg::*;
#(
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned LOG2_AVG = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 start_conversion,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 data_ready,
  output logic [ADC_WIDTH-1:0] avg_data,
  output logic                 avg_valid,
  output logic                 timeout_err
`ifdef ADC_ALARM_EN
  ,
  input  logic [ADC_WIDTH-1:0] thr_hi,
  input  logic [ADC_WIDTH-1:0] thr_lo,
  output logic                 alarm
`endif
);

  localparam int unsigned ACC_W    = acc_width(LOG2_AVG);
  localparam int unsigned CNT_W    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned LAST_IDX = (1 << LOG2_AVG) - 1;
  localparam int unsigned PER_W    = cnt_width(PERIOD);
  localparam int unsigned TO_W     = cnt_width(TIMEOUT);

  acq_state_t           state;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     sample_cnt;

  logic                 per_zero_c;
  logic                 to_zero_c;
  logic                 enter_start_c;
  logic                 per_dec_c;
  logic                 to_dec_c;
  logic                 accept_c;
  logic                 last_c;
  logic [ACC_W-1:0]     sum_c;
  logic [ADC_WIDTH-1:0] mean_c;

  // Transition qualifiers, counter controls and the running sum/mean.
  always_comb begin
    enter_start_c = 1'b0;
    per_dec_c     = 1'b0;
    to_dec_c      = 1'b0;
    accept_c      = 1'b0;
    last_c        = 1'b0;
    sum_c         = '0;
    mean_c        = '0;

    enter_start_c = enable && ((state == IDLE) ||
                               ((state == WAIT_TICK) && per_zero_c));
    // Period runs in every active state so starts stay exactly PERIOD apart;
    // timeout also runs during START so it expires TIMEOUT edges after it.
    per_dec_c     = (state != IDLE);
    to_dec_c      = (state == START) || (state == WAIT_DATA);
    accept_c      = enable && (state == WAIT_DATA) && data_ready;
    last_c        = (sample_cnt == CNT_W'(LAST_IDX));
    sum_c         = acc + ACC_W'(adc_data);
    mean_c        = ADC_WIDTH'(sum_c >> LOG2_AVG);
  end

  acq_downcounter #(.WIDTH(PER_W)) u_period (
    .clk        (clk),
    .reset      (reset),
    .load       (enter_start_c),
    .load_value (PER_W'(PERIOD - 1)),
    .dec        (per_dec_c),
    .zero_c     (per_zero_c)
  );

  acq_downcounter #(.WIDTH(TO_W)) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load       (enter_start_c),
    .load_value (TO_W'(TIMEOUT - 1)),
    .dec        (to_dec_c),
    .zero_c     (to_zero_c)
  );

  // Acquisition state machine with registered pulses and averaging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      start_conversion <= 1'b0;
      avg_valid        <= 1'b0;
      timeout_err      <= 1'b0;
      avg_data         <= '0;
      acc              <= '0;
      sample_cnt       <= '0;
    end else begin
      start_conversion <= enter_start_c;
      avg_valid        <= 1'b0;
      timeout_err      <= 1'b0;

      if (!enable) begin
        // Drop any partial average; the last mean stays on avg_data.
        state      <= IDLE;
        acc        <= '0;
        sample_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= START;
          end
          START: begin
            state <= WAIT_DATA;
          end
          WAIT_DATA: begin
            if (accept_c) begin
              state <= WAIT_TICK;
              if (last_c) begin
                avg_data   <= mean_c;
                avg_valid  <= 1'b1;
                acc        <= '0;
                sample_cnt <= '0;
              end else begin
                acc        <= sum_c;
                sample_cnt <= sample_cnt + CNT_W'(1);
              end
            end else if (to_zero_c) begin
              timeout_err <= 1'b1;
              state       <= WAIT_TICK;
            end
          end
          WAIT_TICK: begin
            if (per_zero_c) begin
              state <= START;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef ADC_ALARM_EN
  // Hysteretic alarm evaluated on each new mean; set wins over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (accept_c && last_c) begin
      if (mean_c > thr_hi) begin
        alarm <= 1'b1;
      end else if (mean_c < thr_lo) begin
        alarm <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Self-checking bench for adc_acq_ctrl: vector table, hand-written corner
// sequences and randomized conversions against a queue-based mean model.
module tb_adc_acq_ctrl;

  localparam int unsigned P    = 100;
  localparam int unsigned L    = 2;
  localparam int unsigned T    = 40;
  localparam int unsigned RESP = 35;
  localparam int unsigned NAVG = 1 << L;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        data_ready;
  logic [15:0] adc_data;
  logic        start_conversion;
  logic        avg_valid;
  logic        timeout_err;
  logic [15:0] avg_data;

  logic        en2;
  logic        dr2;
  logic [15:0] ad2;
  logic        st2;
  logic        av2;
  logic        to2;
  logic [15:0] avg2;

`ifdef ADC_ALARM_EN
  logic [15:0] thr_hi;
  logic [15:0] thr_lo;
  logic        alarm;
  logic        alarm2;
  bit          exp_alarm = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  adc_acq_ctrl #(.PERIOD(P), .LOG2_AVG(L), .TIMEOUT(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .start_conversion (start_conversion),
    .adc_data         (adc_data),
    .data_ready       (data_ready),
    .avg_data         (avg_data),
    .avg_valid        (avg_valid),
    .timeout_err      (timeout_err)
`ifdef ADC_ALARM_EN
    ,
    .thr_hi           (thr_hi),
    .thr_lo           (thr_lo),
    .alarm            (alarm)
`endif
  );

  adc_acq_ctrl #(.PERIOD(P), .LOG2_AVG(0), .TIMEOUT(T)) dut_pt (
    .clk              (clk),
    .reset            (reset),
    .enable           (en2),
    .start_conversion (st2),
    .adc_data         (ad2),
    .data_ready       (dr2),
    .avg_data         (avg2),
    .avg_valid        (av2),
    .timeout_err      (to2)
`ifdef ADC_ALARM_EN
    ,
    .thr_hi           (thr_hi),
    .thr_lo           (thr_lo),
    .alarm            (alarm2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  int          prev_start = -1;
  int          last_wait  = 0;
  logic [15:0] last_avg   = 16'd0;

  // Wait (bounded) for the next start pulse on the main DUT.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    last_wait = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      last_wait++;
      if (start_conversion) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_seen", 0, 1);
  endtask

  // One conversion: dly = edges after the start edge at which data_ready is
  // sampled high (0 = reader never answers).
  task automatic conv(input logic [15:0] v, input int dly, input bit exp_to,
                      input bit exp_av, input logic [15:0] exp_d);
    bit ok;
    int s;
    int last_j;
    wait_start(ok);
    if (!ok) return;
    s = cyc;
    if (prev_start >= 0) check("start_spacing", 32'(s - prev_start), P);
    prev_start = s;
    if (dly == 1) begin
      data_ready = 1'b1;
      adc_data   = v;
    end
    last_j = (dly > int'(T)) ? dly : int'(T);
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      if (j == dly) begin
        data_ready = 1'b0;
        adc_data   = 16'($urandom);
      end
      check("start_width", start_conversion, 0);
      check("timeout_err", timeout_err, 32'(exp_to && (j == int'(T))));
      check("avg_valid", avg_valid, 32'(exp_av && (j == dly)));
      if (exp_av && (j == dly)) begin
        check("avg_data", avg_data, exp_d);
        last_avg = exp_d;
`ifdef ADC_ALARM_EN
        if (exp_d > thr_hi) exp_alarm = 1'b1;
        else if (exp_d < thr_lo) exp_alarm = 1'b0;
        check("alarm", alarm, exp_alarm);
`endif
      end
      if (j == dly - 1) begin
        data_ready = 1'b1;
        adc_data   = v;
      end
    end
    check("avg_data_held", avg_data, last_avg);
  endtask

  typedef struct {
    logic [15:0] v;
    int          dly;
    bit          to;
    bit          av;
    logic [15:0] d;
  } vec_t;

  vec_t        tbl [19];
  logic [15:0] pt_vals [2];
  logic [15:0] q[$];
  logic [15:0] rv;
  logic [15:0] prev2;
  logic [31:0] sum;
  bit          ok;
  bit          seen_av;
  bit          seen_st;
  bit          seen_to;
  int          r;
  int          dly;
  bit          acc_ok;

  initial begin
    tbl[0]  = '{16'd100,   35, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{16'd200,   35, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{16'd300,   35, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{16'd401,   35, 1'b0, 1'b1, 16'd250};
    tbl[4]  = '{16'd10,    35, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{16'd55,     0, 1'b1, 1'b0, 16'd0};
    tbl[6]  = '{16'd20,    35, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{16'd30,    35, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{16'd40,    35, 1'b0, 1'b1, 16'd25};
    tbl[9]  = '{16'd9999,   1, 1'b1, 1'b0, 16'd0};
    tbl[10] = '{16'd5,     40, 1'b0, 1'b0, 16'd0};
    tbl[11] = '{16'd777,   43, 1'b1, 1'b0, 16'd0};
    tbl[12] = '{16'd6,      2, 1'b0, 1'b0, 16'd0};
    tbl[13] = '{16'd7,     39, 1'b0, 1'b0, 16'd0};
    tbl[14] = '{16'd8,     35, 1'b0, 1'b1, 16'd6};
    tbl[15] = '{16'hFFFF,  35, 1'b0, 1'b0, 16'd0};
    tbl[16] = '{16'hFFFF,  10, 1'b0, 1'b0, 16'd0};
    tbl[17] = '{16'hFFFF,  20, 1'b0, 1'b0, 16'd0};
    tbl[18] = '{16'hFFFF,  35, 1'b0, 1'b1, 16'hFFFF};
    pt_vals[0] = 16'hFFFF;
    pt_vals[1] = 16'h0001;

    reset      = 1'b1;
    enable     = 1'b0;
    data_ready = 1'b0;
    adc_data   = 16'd0;
    en2        = 1'b0;
    dr2        = 1'b0;
    ad2        = 16'd0;
`ifdef ADC_ALARM_EN
    thr_hi = 16'd1000;
    thr_lo = 16'd500;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_start", start_conversion, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_avg_data", avg_data, 0);
`ifdef ADC_ALARM_EN
    check("rst_alarm", alarm, 0);
`endif
    reset = 1'b0;
    seen_st = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_st |= start_conversion;
    end
    check("idle_no_start", seen_st, 0);

    // Vector table: averaging, timeout, window boundaries, full scale.
    enable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      conv(tbl[i].v, tbl[i].dly, tbl[i].to, tbl[i].av, tbl[i].d);
      if (i == 0) check("first_start_latency", last_wait, 1);
    end

    // Enable drop after two samples, with a late strobe while idle.
    conv(16'd1000, RESP, 1'b0, 1'b0, 16'd0);
    conv(16'd2000, RESP, 1'b0, 1'b0, 16'd0);
    wait_start(ok);
    repeat (10) @(negedge clk);
    enable     = 1'b0;
    prev_start = -1;
    seen_av = 1'b0;
    seen_st = 1'b0;
    seen_to = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      seen_av |= avg_valid;
      seen_st |= start_conversion;
      seen_to |= timeout_err;
      if (i == 25) begin
        data_ready = 1'b1;
        adc_data   = 16'd3000;
      end
      if (i == 26) data_ready = 1'b0;
    end
    check("drop_no_valid", seen_av, 0);
    check("drop_no_start", seen_st, 0);
    check("drop_no_timeout", seen_to, 0);
    check("drop_avg_held", avg_data, last_avg);
    enable = 1'b1;
    conv(16'd40, RESP, 1'b0, 1'b0, 16'd0);
    check("reenable_latency", last_wait, 1);
    conv(16'd80, RESP, 1'b0, 1'b0, 16'd0);
    conv(16'd120, RESP, 1'b0, 1'b0, 16'd0);
    conv(16'd160, RESP, 1'b0, 1'b1, 16'd100);

`ifdef ADC_ALARM_EN
    // Hysteresis: means 1200, 800, 400 against 1000/500.
    for (int k = 0; k < NAVG; k++) conv(16'd1200, RESP, 1'b0, k == NAVG - 1, 16'd1200);
    check("alarm_set", alarm, 1);
    for (int k = 0; k < NAVG; k++) conv(16'd800, RESP, 1'b0, k == NAVG - 1, 16'd800);
    check("alarm_hold", alarm, 1);
    for (int k = 0; k < NAVG; k++) conv(16'd400, RESP, 1'b0, k == NAVG - 1, 16'd400);
    check("alarm_clear", alarm, 0);
`endif

    // Randomized conversions against a queue model of accepted samples.
    q.delete();
    for (int n = 0; n < 24; n++) begin
      rv = 16'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r == 0) dly = 0;
      else if (r == 1) dly = 1;
      else if (r == 2) dly = int'(T) + int'($urandom_range(1, 5));
      else dly = int'($urandom_range(2, T));
      acc_ok = (dly >= 2) && (dly <= int'(T));
      if (acc_ok) begin
        q.push_back(rv);
        if (q.size() == NAVG) begin
          sum = 32'd0;
          foreach (q[k]) sum += 32'(q[k]);
          q.delete();
          conv(rv, dly, 1'b0, 1'b1, 16'(sum / NAVG));
        end else begin
          conv(rv, dly, 1'b0, 1'b0, 16'd0);
        end
      end else begin
        conv(rv, dly, 1'b1, 1'b0, 16'd0);
      end
    end

    // Asynchronous reset in the middle of WAIT_DATA.
    wait_start(ok);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_start", start_conversion, 0);
    check("areset_avg_valid", avg_valid, 0);
    check("areset_timeout", timeout_err, 0);
    check("areset_avg_data", avg_data, 0);
`ifdef ADC_ALARM_EN
    check("areset_alarm", alarm, 0);
    exp_alarm = 1'b0;
`endif
    seen_st = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      seen_st |= start_conversion;
    end
    check("reset_no_start", seen_st, 0);
    reset      = 1'b0;
    prev_start = -1;
    last_avg   = 16'd0;
    conv(16'd500, RESP, 1'b0, 1'b0, 16'd0);
    check("post_reset_latency", last_wait, 1);
    conv(16'd600, RESP, 1'b0, 1'b0, 16'd0);
    conv(16'd700, RESP, 1'b0, 1'b0, 16'd0);
    conv(16'd800, RESP, 1'b0, 1'b1, 16'd650);
    enable = 1'b0;

    // Pass-through instance: every sample becomes the mean.
    en2   = 1'b1;
    prev2 = 16'd0;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 2 * P; i++) begin
        @(negedge clk);
        if (st2) begin
          ok = 1'b1;
          break;
        end
      end
      check("pt_start_seen", ok, 1);
      check("pt_avg_held", avg2, prev2);
      repeat (RESP - 1) @(negedge clk);
      dr2 = 1'b1;
      ad2 = pt_vals[k];
      @(negedge clk);
      dr2 = 1'b0;
      check("pt_avg_valid", av2, 1);
      check("pt_avg_data", avg2, pt_vals[k]);
`ifdef ADC_ALARM_EN
      check("pt_alarm", alarm2, (k == 0) ? 1 : 0);
`endif
      @(negedge clk);
      check("pt_valid_pulse", av2, 0);
      check("pt_timeout", to2, 0);
      prev2 = pt_vals[k];
    end
    en2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
